// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES serial load front-end.
package aes_pkg;

  localparam int AES_BLOCK_W  = 128;
  localparam int BYTE_W       = 8;
  localparam int BLOCK_BYTES  = AES_BLOCK_W / BYTE_W;
  localparam int BIT_CNT_W    = $clog2(BYTE_W);
  localparam int BYTE_CNT_W   = $clog2(BLOCK_BYTES);
  localparam int IDX_W        = $clog2(AES_BLOCK_W);

  typedef enum logic [1:0] {
    KEY   = 2'd0,
    TEXT  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/aes_bit_pos_cnt.sv
// Tracks the position of the next serial bit inside a 128-bit block.
// Byte k lands at block[127-8k -: 8] and bit i of a byte at offset i, so the
// write index is 8*(15-byte_cnt) + bit_cnt, i.e. {~byte_cnt, bit_cnt}.
module aes_bit_pos_cnt
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_en,
  input  logic             sin_ready,
  output logic             accept,
  output logic             block_last,
  output logic [IDX_W-1:0] wr_idx
);

  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BYTE_CNT_W-1:0] byte_cnt;

  assign accept     = sin_en && sin_ready;
  assign block_last = accept && (bit_cnt == {BIT_CNT_W{1'b1}})
                             && (byte_cnt == {BYTE_CNT_W{1'b1}});
  assign wr_idx     = {~byte_cnt, bit_cnt};

  // Advance bit/byte counters on every accepted bit; both wrap naturally at block end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= bit_cnt + 1'b1;
      if (bit_cnt == {BIT_CNT_W{1'b1}}) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_serial_load_ctrl.sv
// Serial-to-block front-end for the AES core: loads a key and/or a plaintext
// block bit-serially, then runs the start/done handshake with the core.
//
// Serial handshake: a bit transfers on a rising edge where sin_en && sin_ready;
// sin_en while sin_ready is low is ignored and may be held or dropped freely.
module aes_serial_load_ctrl
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sin_en,
  input  logic                   sin,
  input  logic                   rekey,
  output logic                   sin_ready,
  output logic [AES_BLOCK_W-1:0] key_out,
  output logic                   key_valid,
  output logic [AES_BLOCK_W-1:0] text_out,
  output logic                   aes_start,
  input  logic                   aes_done,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  state_t           state;
  logic             accept;
  logic             block_last;
  logic [IDX_W-1:0] wr_idx;

  assign dbg_state = state;

  aes_bit_pos_cnt u_pos (
    .clk        (clk),
    .reset      (reset),
    .sin_en     (sin_en),
    .sin_ready  (sin_ready),
    .accept     (accept),
    .block_last (block_last),
    .wr_idx     (wr_idx)
  );

  // Load sequencer: key -> text -> start -> wait, bits written straight into
  // the destination register; all handshake outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= KEY;
      key_out   <= '0;
      text_out  <= '0;
      key_valid <= 1'b0;
      aes_start <= 1'b0;
      busy      <= 1'b0;
      sin_ready <= 1'b1;
    end else begin
      key_valid <= 1'b0;
      case (state)
        KEY: begin
          if (accept) begin
            key_out[wr_idx] <= sin;
            if (block_last) begin
              key_valid <= 1'b1;
              state     <= TEXT;
            end
          end
        end
        TEXT: begin
          if (accept) begin
            text_out[wr_idx] <= sin;
            if (block_last) begin
              state     <= START;
              aes_start <= 1'b1;
              busy      <= 1'b1;
              sin_ready <= 1'b0;
            end
          end
        end
        START: begin
          // aes_done is deliberately not looked at here.
          aes_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (aes_done) begin
            busy      <= 1'b0;
            sin_ready <= 1'b1;
            state     <= rekey ? KEY : TEXT;
          end
        end
        default: begin
          state <= KEY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_serial_load_ctrl.sv
// Directed bench for aes_serial_load_ctrl: key/text loads, start/done
// handshake, rekey, gapped stream, mid-frame reset and spurious done.
module tb_aes_serial_load_ctrl;

  localparam logic [1:0] S_KEY   = 2'd0;
  localparam logic [1:0] S_TEXT  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] TE = {16{8'hee}};
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K3 = 128'h603deb1015ca71be2b73aef0857d7781;

  logic         clk;
  logic         reset;
  logic         sin_en;
  logic         sin;
  logic         rekey;
  logic         sin_ready;
  logic [127:0] key_out;
  logic         key_valid;
  logic [127:0] text_out;
  logic         aes_start;
  logic         aes_done;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_tests;
  int n_fail;
  int kv_cnt;
  int st_cnt;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_serial_load_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .sin_en    (sin_en),
    .sin       (sin),
    .rekey     (rekey),
    .sin_ready (sin_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .text_out  (text_out),
    .aes_start (aes_start),
    .aes_done  (aes_done),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      kv_cnt <= kv_cnt;
    end else begin
      if (key_valid === 1'b1) kv_cnt <= kv_cnt + 1;
      if (aes_start === 1'b1) st_cnt <= st_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Driver: send the first nbits of blk, bytes MSB-byte first, bits LSB-first.
  task automatic send_stream(input logic [127:0] blk, input int nbits, input int gap_max);
    logic [7:0] b;
    int gap;
    for (int n = 0; n < nbits; n++) begin
      b      = blk[127 - 8*(n/8) -: 8];
      sin_en = 1'b1;
      sin    = b[n % 8];
      tick();
      sin_en = 1'b0;
      sin    = 1'b0;
      if (gap_max > 0 && n != nbits - 1) begin
        gap = $urandom_range(0, gap_max);
        repeat (gap) tick();
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},     128'(dbg_state), 128'(S_KEY));
    check({tag, "_key_out"},   key_out, 128'h0);
    check({tag, "_text_out"},  text_out, 128'h0);
    check({tag, "_key_valid"}, 128'(key_valid), 128'h0);
    check({tag, "_aes_start"}, 128'(aes_start), 128'h0);
    check({tag, "_busy"},      128'(busy), 128'h0);
    check({tag, "_sin_ready"}, 128'(sin_ready), 128'h1);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    kv_cnt   = 0;
    st_cnt   = 0;
    reset    = 1'b1;
    sin_en   = 1'b0;
    sin      = 1'b0;
    rekey    = 1'b0;
    aes_done = 1'b0;
    repeat (3) tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();

    // Key load
    send_stream(K1, 128, 0);
    check("k1_key_valid", 128'(key_valid), 128'h1);
    check("k1_state",     128'(dbg_state), 128'(S_TEXT));
    check("k1_key_out",   key_out, K1);
    check("k1_sin_ready", 128'(sin_ready), 128'h1);
    tick();
    check("k1_kv_drop",   128'(key_valid), 128'h0);
    check("k1_kv_count",  128'(kv_cnt), 128'd1);

    // Text load; aes_done in the START cycle must be ignored
    send_stream(T1, 128, 0);
    check("t1_state",     128'(dbg_state), 128'(S_START));
    check("t1_aes_start", 128'(aes_start), 128'h1);
    check("t1_busy",      128'(busy), 128'h1);
    check("t1_sin_ready", 128'(sin_ready), 128'h0);
    check("t1_text_out",  text_out, T1);
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    check("t1_wait_state", 128'(dbg_state), 128'(S_WAIT));
    check("t1_start_drop", 128'(aes_start), 128'h0);
    check("t1_wait_busy",  128'(busy), 128'h1);
    // sin_en during WAIT must be ignored
    for (int i = 0; i < 6; i++) begin
      sin_en = 1'b1;
      sin    = ~sin;
      tick();
    end
    sin_en = 1'b0;
    sin    = 1'b0;
    check("wait_text_hold",  text_out, T1);
    check("wait_state_hold", 128'(dbg_state), 128'(S_WAIT));
    check("t1_start_count",  128'(st_cnt), 128'd1);

    // Done with rekey=0 -> TEXT, key untouched
    rekey    = 1'b0;
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    check("done0_state",     128'(dbg_state), 128'(S_TEXT));
    check("done0_sin_ready", 128'(sin_ready), 128'h1);
    check("done0_busy",      128'(busy), 128'h0);
    check("done0_key_out",   key_out, K1);

    // Spurious done in TEXT
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    check("sp_text_state", 128'(dbg_state), 128'(S_TEXT));

    // Gapped text stream
    send_stream(TE, 128, 5);
    check("te_state",    128'(dbg_state), 128'(S_START));
    check("te_text_out", text_out, TE);
    check("te_key_out",  key_out, K1);

    // Hold done high from START through WAIT with rekey=1: exactly one exit
    rekey    = 1'b1;
    aes_done = 1'b1;
    tick();
    check("hold_wait_state", 128'(dbg_state), 128'(S_WAIT));
    tick();
    check("hold_exit_state", 128'(dbg_state), 128'(S_KEY));
    repeat (4) tick();
    check("hold_stay_key",   128'(dbg_state), 128'(S_KEY));
    check("hold_start_cnt",  128'(st_cnt), 128'd2);
    check("hold_kv_cnt",     128'(kv_cnt), 128'd1);
    aes_done = 1'b0;
    rekey    = 1'b0;

    // Rekey: next 128 bits replace the key
    send_stream(K2, 128, 0);
    check("k2_key_out", key_out, K2);
    check("k2_state",   128'(dbg_state), 128'(S_TEXT));
    tick();
    check("k2_kv_cnt",  128'(kv_cnt), 128'd2);

    // Reset mid-frame after 37 key bits
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst2_state", 128'(dbg_state), 128'(S_KEY));
    send_stream({128{1'b1}}, 37, 0);
    check("partial_state", 128'(dbg_state), 128'(S_KEY));
    reset = 1'b1;
    tick();
    check_reset_values("rst3");
    reset = 1'b0;
    tick();

    // Spurious done in KEY, then clean key load
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    check("sp_key_state", 128'(dbg_state), 128'(S_KEY));
    send_stream(K3, 128, 0);
    check("k3_key_out",   key_out, K3);
    check("k3_key_valid", 128'(key_valid), 128'h1);
    check("k3_state",     128'(dbg_state), 128'(S_TEXT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
